// File: rtl/z88_video_pkg.sv
// Shared Z88 video definitions: 640x480@60 VGA timing, LCD geometry and colour type.
package z88_video_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int LCD_LINES   = 64;
   localparam int LCD_NIBBLES = 160;

   // {R[3:0], G[3:0], B[3:0]}
   typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA raster counters with raw (unpipelined) sync and active decode.
module vga_timing
   import z88_video_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_ena,
   output logic [9:0] hcnt,
   output logic [9:0] vcnt,
   output logic       active,
   output logic       hs,
   output logic       vs
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pix_ena) begin
         if (hcnt == 10'(H_TOTAL - 1)) begin
            hcnt <= '0;
            vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? '0 : vcnt + 10'd1;
         end else begin
            hcnt <= hcnt + 10'd1;
         end
      end
   end

   // Syncs are active low.
   assign active = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
   assign hs     = !((hcnt >= 10'(H_ACTIVE + H_FP)) && (hcnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
   assign vs     = !((vcnt >= 10'(V_ACTIVE + V_FP)) && (vcnt < 10'(V_ACTIVE + V_FP + V_SYNC)));

endmodule

// File: rtl/lcd_scanout.sv
// Reads the 640x64 LCD image from VRAM and shows it 4x vertically scaled inside a
// bordered 640x480 VGA frame; counters to pins is a fixed 2 pix_ena cycle pipeline.
module lcd_scanout
   import z88_video_pkg::*;
#(
   parameter int      V_TOP      = 112,
   parameter rgb444_t COL_ON     = 12'h222,
   parameter rgb444_t COL_OFF    = 12'hCDB,
   parameter rgb444_t COL_BORDER = 12'h446
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_ena,
   input  logic        lcdon,
   output logic [13:0] o_vram_a,
   input  logic [3:0]  i_vram_di,
   output logic        o_hs,
   output logic        o_vs,
   output logic        o_de,
   output logic [11:0] o_rgb,
   output logic        o_vblank
);

   logic [9:0]  hcnt;
   logic [9:0]  vcnt;
   logic        raw_active;
   logic        raw_hs;
   logic        raw_vs;
   logic        raw_vblank;
   logic        in_window;
   logic [5:0]  lcd_line;
   logic [13:0] addr_live;
   logic [13:0] addr_hold;

   logic [3:0]  s1_di;
   logic [1:0]  s1_sel;
   logic        s1_win;
   logic        s1_act;
   logic        s1_hs;
   logic        s1_vs;
   logic        s1_vblank;
   logic        s1_lcdon;
   logic        s1_pixel;
   rgb444_t     rgb_next;

   vga_timing u_timing (
      .clk     (clk),
      .rst     (rst),
      .pix_ena (pix_ena),
      .hcnt    (hcnt),
      .vcnt    (vcnt),
      .active  (raw_active),
      .hs      (raw_hs),
      .vs      (raw_vs)
   );

   assign raw_vblank = (hcnt == 10'd0) && (vcnt == 10'(V_ACTIVE));
   assign in_window  = raw_active && (vcnt >= 10'(V_TOP)) && (vcnt < 10'(V_TOP + 256));
   assign lcd_line   = 6'((vcnt - 10'(V_TOP)) >> 2);
   assign addr_live  = {lcd_line, hcnt[9:2]};

   // Outside the window the address freezes on the last fetched nibble, so the
   // read port never sees an address past nibble 159.
   assign o_vram_a = in_window ? addr_live : addr_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_hold <= '0;
      end else if (pix_ena && in_window) begin
         addr_hold <= addr_live;
      end
   end

   // Stage 1: VRAM data lands together with the controls of the pixel that fetched it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_di     <= '0;
         s1_sel    <= '0;
         s1_win    <= 1'b0;
         s1_act    <= 1'b0;
         s1_hs     <= 1'b1;
         s1_vs     <= 1'b1;
         s1_vblank <= 1'b0;
         s1_lcdon  <= 1'b0;
      end else if (pix_ena) begin
         s1_di     <= i_vram_di;
         s1_sel    <= hcnt[1:0];
         s1_win    <= in_window;
         s1_act    <= raw_active;
         s1_hs     <= raw_hs;
         s1_vs     <= raw_vs;
         s1_vblank <= raw_vblank;
         s1_lcdon  <= lcdon;
      end
   end

   // MSB of the nibble is the leftmost of its four pixels.
   assign s1_pixel = s1_di[2'd3 - s1_sel];

   always_comb begin
      rgb_next = '0;
      if (s1_win) begin
         rgb_next = (s1_lcdon && s1_pixel) ? COL_ON : COL_OFF;
      end else if (s1_act) begin
         rgb_next = COL_BORDER;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_hs     <= 1'b1;
         o_vs     <= 1'b1;
         o_de     <= 1'b0;
         o_rgb    <= '0;
         o_vblank <= 1'b0;
      end else if (pix_ena) begin
         o_hs     <= s1_hs;
         o_vs     <= s1_vs;
         o_de     <= s1_act;
         o_rgb    <= rgb_next;
         o_vblank <= s1_vblank;
      end
   end

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: random VRAM/lcdon/pix_ena stimulus against a raster-level
// reference model, plus literal spot values, sync/DE timing and async reset checks.
module tb_lcd_scanout;

   localparam int          V_TOP = 112;
   localparam logic [11:0] C_ON  = 12'h222;
   localparam logic [11:0] C_OFF = 12'hCDB;
   localparam logic [11:0] C_BRD = 12'h446;
   // Packed expected output word: {hs, vs, de, vblank, rgb[11:0]}
   localparam logic [15:0] CLEARED = {1'b1, 1'b1, 1'b0, 1'b0, 12'h000};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_ena = 1'b0;
   logic        lcdon = 1'b0;
   logic [13:0] vram_a;
   logic [3:0]  vram_di;
   logic        hs;
   logic        vs;
   logic        de;
   logic [11:0] rgb;
   logic        vblank;

   logic [3:0]  mem [0:16383];
   assign vram_di = mem[vram_a];

   lcd_scanout #(
      .V_TOP      (V_TOP),
      .COL_ON     (C_ON),
      .COL_OFF    (C_OFF),
      .COL_BORDER (C_BRD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_ena   (pix_ena),
      .lcdon     (lcdon),
      .o_vram_a  (vram_a),
      .i_vram_di (vram_di),
      .o_hs      (hs),
      .o_vs      (vs),
      .o_de      (de),
      .o_rgb     (rgb),
      .o_vblank  (vblank)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   int          hq[$];
   int          vq[$];
   int          k;
   logic [13:0] last_addr;
   int          lcd_mode;
   int          hs_fall;
   int          vs_fall;
   int          de_cnt;
   int          vb_cnt;
   logic        prev_hs;
   logic        prev_vs;
   logic        vb_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv,
                        input int h, input int v);
      checks++;
      if (act !== expv) begin
         errors++;
         if (errors <= 50)
            $display("FAIL %s at h=%0d v=%0d actual %0h required %0h", name, h, v, act, expv);
      end
   endtask

   // Expected pins for raster position (h, v) straight from the display rules.
   function automatic logic [15:0] model_out(input int h, input int v, input logic on);
      logic        act;
      logic        win;
      logic [3:0]  nb;
      logic        px;
      logic [11:0] c;
      act = (h < 640) && (v < 480);
      win = act && (v >= V_TOP) && (v < V_TOP + 256);
      c   = 12'h000;
      if (win) begin
         nb = mem[((v - V_TOP) / 4) * 256 + h / 4];
         px = nb[3 - (h % 4)];
         c  = (on && px) ? C_ON : C_OFF;
      end else if (act) begin
         c = C_BRD;
      end
      return {!((h >= 656) && (h < 752)), !((v >= 490) && (v < 492)), act, (h == 0) && (v == 480), c};
   endfunction

   task automatic model_reset();
      exp_q.delete(); hq.delete(); vq.delete();
      repeat (2) begin
         exp_q.push_back(CLEARED);
         hq.push_back(-1);
         vq.push_back(-1);
      end
      k = 0;
      last_addr = 14'h0;
      hs_fall = -1;
      vs_fall = -1;
      de_cnt = 0;
      vb_cnt = 0;
      prev_hs = 1'b1;
      prev_vs = 1'b1;
      vb_seen = 1'b0;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [15:0] e;
      logic [15:0] act;
      logic [13:0] addr;
      int eh, ev, h, v;
      if (!rst) begin
         act = {hs, vs, de, vblank, rgb};
         if (pix_ena) begin
            e  = exp_q.pop_front();
            eh = hq.pop_front();
            ev = vq.pop_front();
            check("pins", 32'(act), 32'(e), eh, ev);

            if (lcd_mode == 0 && ev >= V_TOP && ev < V_TOP + 4 && eh >= 0 && eh < 4)
               check("pixel_order", 32'(rgb), (eh == 0) ? 32'(C_ON) : 32'(C_OFF), eh, ev);
            if ((ev == V_TOP - 1 || ev == V_TOP + 256) && eh == 0)
               check("border_row", 32'(rgb), 32'(C_BRD), eh, ev);
            if (lcd_mode == 1 && ev == V_TOP + 100 && eh == 10)
               check("lcdoff_window", 32'(rgb), 32'(C_OFF), eh, ev);
            if (lcd_mode == 1 && ev == V_TOP + 100 && eh == 700)
               check("blank_rgb", 32'(rgb), 32'h0, eh, ev);

            if (prev_hs && !hs) begin
               if (hs_fall < 0) check("hs_first_fall", 32'(k), 32'd658, eh, ev);
               else             check("hs_period", 32'(k - hs_fall), 32'd800, eh, ev);
               hs_fall = k;
            end
            if (!prev_hs && hs && hs_fall >= 0) check("hs_low", 32'(k - hs_fall), 32'd96, eh, ev);
            if (prev_vs && !vs) begin
               if (vs_fall >= 0) check("vs_period", 32'(k - vs_fall), 32'd420000, eh, ev);
               vs_fall = k;
            end
            if (!prev_vs && vs && vs_fall >= 0) check("vs_low", 32'(k - vs_fall), 32'd1600, eh, ev);
            if (de) de_cnt++;
            if (vblank) begin
               vb_cnt++;
               if (vb_seen) check("de_per_frame", 32'(de_cnt), 32'd307200, eh, ev);
               vb_seen = 1'b1;
               de_cnt = 0;
            end
            prev_hs = hs;
            prev_vs = vs;

            h = k % 800;
            v = (k / 800) % 525;
            if ((h < 640) && (v >= V_TOP) && (v < V_TOP + 256)) begin
               addr = 14'(((v - V_TOP) / 4) * 256 + h / 4);
               last_addr = addr;
            end else begin
               addr = last_addr;
            end
            check("vram_a", 32'(vram_a), 32'(addr), h, v);
            if (v == V_TOP + 5 && h == 8)     check("addr_line1", 32'(vram_a), 32'h0102, h, v);
            if (v == V_TOP + 255 && h == 636) check("addr_last", 32'(vram_a), 32'h3F9F, h, v);
            if (v == V_TOP + 255 && h == 700) check("addr_hold", 32'(vram_a), 32'h3F9F, h, v);

            exp_q.push_back(model_out(h, v, lcdon));
            hq.push_back(h);
            vq.push_back(v);
            k++;
         end else begin
            check("stall_hold", 32'(act), 32'(exp_q[0]), hq[0], vq[0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_lcdon();
      case (lcd_mode)
         0:       lcdon = 1'b1;
         1:       lcdon = 1'b0;
         default: lcdon = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic run_pix(input int n, input bit stall);
      for (int i = 0; i < n; i++) begin
         if (stall) begin
            int gap;
            gap = $urandom_range(0, 6);
            for (int g = 0; g < gap; g++) begin
               @(posedge clk); #1;
               pix_ena = 1'b0;
               drive_lcdon();
            end
         end
         @(posedge clk); #1;
         pix_ena = 1'b1;
         drive_lcdon();
      end
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_hs"},     32'(hs),     32'd1, -1, -1);
      check({tag, "_vs"},     32'(vs),     32'd1, -1, -1);
      check({tag, "_de"},     32'(de),     32'd0, -1, -1);
      check({tag, "_rgb"},    32'(rgb),    32'd0, -1, -1);
      check({tag, "_vblank"}, 32'(vblank), 32'd0, -1, -1);
      check({tag, "_vram_a"}, 32'(vram_a), 32'd0, -1, -1);
   endtask

   // Reset asserted between edges while the raster sits at hcnt=300, vcnt=200.
   task automatic async_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_reset_pins("async_rst");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 16384; i++) mem[i] = 4'($urandom_range(0, 15));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      fill_random();
      mem[0] = 4'b1000;
      lcd_mode = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_pins("por");
      @(posedge clk); #1;
      rst = 1'b0;

      run_pix(200 * 800 + 300, 1'b0);
      async_reset();

      run_pix(420000, 1'b0);
      lcd_mode = 1;
      for (int i = 0; i < 16384; i++) mem[i] = 4'hF;
      run_pix(420000, 1'b0);
      @(posedge clk); #1;
      pix_ena = 1'b0;
      check("vblank_count", 32'(vb_cnt), 32'd2, -1, -1);

      fill_random();
      lcd_mode = 2;
      run_pix(110000, 1'b1);
      @(posedge clk); #1;
      pix_ena = 1'b0;
      repeat (4) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
